// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port synchronous data RAM between the CPU
// datapath (port C) and the debug/program-loader port (port D).
// Round-robin per access; port D may lock ownership for a bounded burst.
//
// Handshake: a port's access transfers in any cycle where req & gnt = 1.
// gnt is combinational from req and the registered arbitration state, at most
// one gnt is high per cycle, and a requester holds req/we/addr/wdata stable
// until it sees gnt. Read data returns exactly one cycle after the granted
// read, flagged by the owner's rvalid; writes never produce rvalid.
module dmem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int MAX_LOCK = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic          d_lock,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    dbg_state
);

  localparam int CW = $clog2(MAX_LOCK) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_LOCK - 1);

  localparam logic [1:0] ST_OPEN    = 2'd0;
  localparam logic [1:0] ST_LOCKED  = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic [1:0]    state, state_nx;
  logic          last_d, last_d_nx;   // 1: port D owned the most recent grant
  logic [CW-1:0] lock_cnt, lock_cnt_nx;
  logic          tag_valid;           // a read was granted last cycle
  logic          tag_d;               // ... and port D owned it

  assign dbg_state = state;

  // Grant decision: lock gives D absolute priority, release hands one cycle to C.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      case (state)
        ST_LOCKED:  d_gnt = d_req;
        ST_RELEASE: c_gnt = c_req;
        default: begin
          if (c_req && d_req) begin
            c_gnt = last_d;
            d_gnt = !last_d;
          end else begin
            c_gnt = c_req;
            d_gnt = d_req;
          end
        end
      endcase
    end
  end

  // Next arbitration state; dropping d_lock wins over counter expiry.
  always_comb begin
    state_nx    = state;
    last_d_nx   = last_d;
    lock_cnt_nx = lock_cnt;
    case (state)
      ST_LOCKED: begin
        if (!d_lock) begin
          state_nx    = ST_OPEN;
          last_d_nx   = 1'b1;
          lock_cnt_nx = '0;
        end else if (lock_cnt == CNT_LAST) begin
          state_nx    = ST_RELEASE;
          lock_cnt_nx = '0;
        end else begin
          lock_cnt_nx = lock_cnt + CW'(1);
        end
      end
      ST_RELEASE: begin
        state_nx  = ST_OPEN;
        last_d_nx = 1'b1;
      end
      default: begin
        if (d_gnt) begin
          last_d_nx = 1'b1;
          if (d_lock) begin
            state_nx    = ST_LOCKED;
            lock_cnt_nx = CW'(1);
          end
        end else if (c_gnt) begin
          last_d_nx = 1'b0;
        end
      end
    endcase
  end

  // Arbitration state registers; reset leaves D as last owner so C wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_OPEN;
      last_d   <= 1'b1;
      lock_cnt <= '0;
    end else begin
      state    <= state_nx;
      last_d   <= last_d_nx;
      lock_cnt <= lock_cnt_nx;
    end
  end

  // RAM drive: mux the granted port, all zero when idle.
  always_comb begin
    mem_en    = c_gnt | d_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (c_gnt) begin
      mem_we    = c_we;
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
    end else if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  // Read tag: remembers who owns the data the RAM returns next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid <= 1'b0;
      tag_d     <= 1'b0;
    end else begin
      tag_valid <= mem_en & ~mem_we;
      tag_d     <= d_gnt;
    end
  end

  // Read return steering; rst masks a read that was in flight.
  always_comb begin
    c_rvalid = tag_valid & ~tag_d & ~rst;
    d_rvalid = tag_valid & tag_d & ~rst;
    c_rdata  = c_rvalid ? mem_rdata : '0;
    d_rdata  = d_rvalid ? mem_rdata : '0;
  end

endmodule
